// File: rtl/acc4_seq.sv
// ---------------------------------------------------------------------------
// acc4_seq -- sequenced 4-bit signed accumulator around an external adder.
//
// Each accepted operand is held in B while the accumulator drives A. The
// external ripple-carry adder gets SETTLE_CYCLES clocks to settle. Its sum
// S_rca (and overflow O_rca) is then captured into the accumulator.
//
// Parameter:
//   SETTLE_CYCLES  adder settle time in clocks, legal range 1..15 (default 2)
//
// Build option:
//   ACC4_SEQ_SAT_EN  when defined, an overflowing capture saturates the
//                    accumulator to 4'b0111 / 4'b1000 (chosen by the sign of
//                    A) instead of wrapping. The sticky flag is unaffected.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   operand offered on in_data
//   in_data     in   [3:0] signed operand
//   in_ready    out  operand accepted this cycle (combinational)
//   clr         in   synchronous clear of accumulator and sticky flag
//   A           out  [3:0] adder operand A (= accumulator)
//   B           out  [3:0] adder operand B (= operand register)
//   S_rca       in   [3:0] adder sum
//   O_rca       in   adder signed overflow
//   acc         out  [3:0] accumulator value (same as A)
//   out_valid   out  one-cycle pulse after acc updates
//   ovf_sticky  out  any overflow since last clear/reset
//
// State  | meaning
// IDLE   | waiting for an operand; in_ready high unless clr
// SETTLE | A/B held stable, counting down the adder settle time
// CAPTURE| adder result sampled into acc, out_valid pulsed
// ---------------------------------------------------------------------------
module acc4_seq #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       clr,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [3:0] S_rca,
  input  logic       O_rca,
  output logic [3:0] acc,
  output logic       out_valid,
  output logic       ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Counter is loaded with SETTLE_CYCLES-1 so that SETTLE spans exactly
  // SETTLE_CYCLES clocks (leaves on the cycle the counter reads zero).
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] acc_q;
  logic [3:0] b_q;
  logic [3:0] cnt_q;
  logic       out_valid_q;
  logic       ovf_q;
  logic [3:0] acc_d;

  // Value loaded into the accumulator at CAPTURE.
  always_comb begin
    acc_d = S_rca;
`ifdef ACC4_SEQ_SAT_EN
    // Overflow can only occur when both operands share A's sign, so A[3]
    // picks the saturation rail.
    if (O_rca) begin
      acc_d = acc_q[3] ? 4'b1000 : 4'b0111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 4'd0;
      b_q         <= 4'd0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (clr) begin
        // B is intentionally kept; any operation in flight is dropped.
        acc_q   <= 4'd0;
        ovf_q   <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid) begin
              b_q     <= in_data;
              cnt_q   <= CNT_LOAD;
              state_q <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt_q == 4'd0) begin
              state_q <= CAPTURE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          CAPTURE: begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_q | O_rca;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready   = (state_q == IDLE) && !clr;
  assign A          = acc_q;
  assign acc        = acc_q;
  assign B          = b_q;
  assign out_valid  = out_valid_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_acc4_seq.sv
// Directed bench for acc4_seq with SETTLE_CYCLES=2. The external adder is
// modelled here from A and B. Expectations follow the build option.
`timescale 1ns/1ps
module tb_acc4_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       clr;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] S_rca;
  logic       O_rca;
  logic [3:0] acc;
  logic       out_valid;
  logic       ovf_sticky;

  int checks;
  int failures;

  acc4_seq #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clr        (clr),
    .A          (A),
    .B          (B),
    .S_rca      (S_rca),
    .O_rca      (O_rca),
    .acc        (acc),
    .out_valid  (out_valid),
    .ovf_sticky (ovf_sticky)
  );

  // External 4-bit ripple-carry adder with signed overflow.
  assign S_rca = A + B;
  assign O_rca = (A[3] == B[3]) && (S_rca[3] != A[3]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       do_clr;
    logic [3:0] data;
    logic [3:0] exp_wrap;
    logic [3:0] exp_sat;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  // Handshake one operand at the current negedge and follow it to capture.
  task automatic send(input logic [3:0] d, input logic [3:0] exp_acc, input logic exp_ovf);
    logic [3:0] a_prev;
    int         bad;
    bad    = 0;
    a_prev = acc;
    check("in_ready_before_send", {3'b0, in_ready}, 4'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (out_valid !== (j == 3)) bad++;
      if (in_ready !== (j == 3)) bad++;
      if (B !== d) bad++;
      if (j < 3 && A !== a_prev) bad++;
    end
    check("send_timing_hold", 4'(bad), 4'd0);
    check("send_acc", acc, exp_acc);
    check("send_ovf", {3'b0, ovf_sticky}, {3'b0, exp_ovf});
  endtask

  task automatic do_clear();
    clr = 1'b1;
    #1;
    check("in_ready_during_clr", {3'b0, in_ready}, 4'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_acc", acc, 4'd0);
    check("clr_ovf", {3'b0, ovf_sticky}, 4'd0);
    check("clr_out_valid", {3'b0, out_valid}, 4'd0);
    check("clr_in_ready", {3'b0, in_ready}, 4'd1);
  endtask

  initial begin
    int bad;
    logic [3:0] exp_acc;
    checks   = 0;
    failures = 0;

    //           clr   data   wrap   sat    ovf
    vecs[0]  = '{1'b0, 4'h3, 4'h3, 4'h3, 1'b0};
    vecs[1]  = '{1'b0, 4'h2, 4'h5, 4'h5, 1'b0};
    vecs[2]  = '{1'b0, 4'h2, 4'h7, 4'h7, 1'b0};
    vecs[3]  = '{1'b0, 4'h1, 4'h8, 4'h7, 1'b1};
    vecs[4]  = '{1'b0, 4'h0, 4'h8, 4'h7, 1'b1};
    vecs[5]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 4'h8, 4'h8, 4'h8, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 4'h7, 4'h8, 1'b1};
    vecs[8]  = '{1'b0, 4'hF, 4'h6, 4'h8, 1'b1};
    vecs[9]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 4'h7, 4'h7, 4'h7, 1'b0};
    vecs[11] = '{1'b0, 4'h7, 4'hE, 4'h7, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    clr      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_acc", acc, 4'd0);
    check("reset_B", B, 4'd0);
    check("reset_ovf", {3'b0, ovf_sticky}, 4'd0);
    check("reset_out_valid", {3'b0, out_valid}, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {3'b0, in_ready}, 4'd1);

    // Vector table: back-to-back operands at full throughput, with clears.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_clr) begin
        do_clear();
      end else begin
`ifdef ACC4_SEQ_SAT_EN
        exp_acc = vecs[i].exp_sat;
`else
        exp_acc = vecs[i].exp_wrap;
`endif
        send(vecs[i].data, exp_acc, vecs[i].exp_ovf);
      end
    end

    // out_valid drops after its single pulse.
    @(negedge clk);
    check("out_valid_single_pulse", {3'b0, out_valid}, 4'd0);

    // Clear during SETTLE, colliding with in_valid: abort, nothing accepted.
    in_valid = 1'b1;
    in_data  = 4'h1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    #1;
    check("clr_settle_in_ready", {3'b0, in_ready}, 4'd0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_settle_in_ready_next", {3'b0, in_ready}, 4'd1);
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      if (out_valid !== 1'b0) bad++;
      if (acc !== 4'd0) bad++;
      if (ovf_sticky !== 1'b0) bad++;
      if (B !== 4'h1) bad++;
      @(negedge clk);
    end
    check("clr_settle_abort", 4'(bad), 4'd0);

    // Continuous in_valid: one handshake per 4 cycles.
    in_valid = 1'b1;
    in_data  = 4'h1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (in_ready !== ((i % 4) == 0)) bad++;
      if (out_valid !== ((i % 4) == 0 && i > 0)) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("throughput_pattern", 4'(bad), 4'd0);
    check("throughput_acc", acc, 4'd4);
    check("throughput_last_pulse", {3'b0, out_valid}, 4'd1);

    // Asynchronous reset in the middle of SETTLE.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'h3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #2;
    check("async_rst_acc", acc, 4'd0);
    check("async_rst_B", B, 4'd0);
    check("async_rst_in_ready", {3'b0, in_ready}, 4'd1);
    check("async_rst_out_valid", {3'b0, out_valid}, 4'd0);
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
      if (acc !== 4'd0) bad++;
      if (in_ready !== 1'b1) bad++;
    end
    check("async_rst_no_capture", 4'(bad), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
